// File: rtl/iddmm_carry_wb_pkg.sv
// Shared constants and types for the IDDMM datapath stages.
package iddmm_pkg;
    localparam int K      = 128;
    localparam int N      = 32;
    localparam int ADDR_W = $clog2(N);
    localparam int LAT    = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [K-1:0]  digit_t;
    typedef logic [ADDR_W:0] jidx_t;
endpackage

// File: rtl/iddmm_carry_wb_if.sv
// Adder-side and result-RAM-side signals of the carry/writeback stage.
interface iddmm_carry_wb_if #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
);
    logic              start;
    logic              first_iter;
    logic              in_valid;
    logic [ADDR_W:0]   j_cnt;
    logic [2*K-1:0]    adder_result;
    logic [K-1:0]      carry_word;
    logic              top_carry;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [K-1:0]      wr_data;
    logic              busy;
    logic              iter_done;
    logic              seq_err;
    logic              lsd_err;

    modport slave (
        input  start, first_iter, in_valid, j_cnt, adder_result,
        output carry_word, top_carry, wr_en, wr_addr, wr_data,
               busy, iter_done, seq_err, lsd_err
    );
    modport master (
        output start, first_iter, in_valid, j_cnt, adder_result,
        input  carry_word, top_carry, wr_en, wr_addr, wr_data,
               busy, iter_done, seq_err, lsd_err
    );
endinterface

// File: rtl/iddmm_align_pipe.sv
// LAT-deep delay line for an issue-valid bit and its digit index.
module iddmm_align_pipe #(
    parameter int LAT = 2,
    parameter int JW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [JW-1:0] j_in,
    output logic          r_valid,
    output logic [JW-1:0] r_j
);
    logic [LAT-1:0] v_q;
    logic [JW-1:0]  j_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) j_q[i] <= '0;
        end else begin
            v_q[0] <= in_valid;
            j_q[0] <= j_in;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                j_q[i] <= j_q[i-1];
            end
        end
    end

    assign r_valid = v_q[LAT-1];
    assign r_j     = j_q[LAT-1];
endmodule

// File: rtl/iddmm_carry_wb.sv
// Carry/writeback stage: splits adder sums into result digits (written one digit down) and carry feedback.
module iddmm_carry_wb #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int LAT    = 2,
    parameter int ADDR_W = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    iddmm_carry_wb_if.slave bus
);
    import iddmm_pkg::*;

    // state | meaning
    // IDLE  | waiting for start; aligned beats are dropped
    // RUN   | accepting aligned beats until digit N
    // DONE  | one-cycle iter_done pulse
    localparam logic [ADDR_W:0] J_LAST = (ADDR_W+1)'(N);

    state_t            state_q, state_d;
    logic [K-1:0]      carry_q, carry_d, wr_data_q, wr_data_d, lo, hi;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   exp_q, exp_d, r_j;
    logic              top_q, top_d, wr_en_q, wr_en_d;
    logic              seq_q, seq_d, lsd_q, lsd_d, r_valid;

    iddmm_align_pipe #(.LAT(LAT), .JW(ADDR_W+1)) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(bus.in_valid),
        .j_in    (bus.j_cnt),
        .r_valid (r_valid),
        .r_j     (r_j)
    );

    assign lo = bus.adder_result[K-1:0];
    assign hi = bus.adder_result[2*K-1:K];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carry_q   <= '0;
            top_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            exp_q     <= '0;
            seq_q     <= 1'b0;
            lsd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            top_q     <= top_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            exp_q     <= exp_d;
            seq_q     <= seq_d;
            lsd_q     <= lsd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        carry_d   = carry_q;
        top_d     = top_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        exp_d     = exp_q;
        seq_d     = seq_q;
        lsd_d     = lsd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    carry_d = '0;
                    exp_d   = '0;
                    if (bus.first_iter) top_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (r_valid) begin
                    exp_d = exp_q + 1'b1;
                    if (r_j != exp_q) seq_d = 1'b1;
                    if (r_j == '0) begin
                        if (lo != '0) lsd_d = 1'b1;
                        carry_d = hi;
                    end else if (r_j == J_LAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(N-1);
                        wr_data_d = lo;
                        top_d     = hi[0];
                        carry_d   = '0;
                        if (hi[K-1:1] != '0) seq_d = 1'b1;
                        state_d   = DONE;
                    end else if (r_j < J_LAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(r_j - 1'b1);
                        wr_data_d = lo;
                        carry_d   = hi;
                    end else begin
                        // index beyond N cannot be a legal digit; flag it and leave the RAM alone
                        seq_d   = 1'b1;
                        carry_d = hi;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.carry_word = carry_q;
    assign bus.top_carry  = top_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.iter_done  = (state_q == DONE);
    assign bus.seq_err    = seq_q;
    assign bus.lsd_err    = lsd_q;
endmodule
